// File: rtl/chad_mem_arbiter.sv
// chad_mem_arbiter: shares one synchronous-read data RAM between the chad
// core's data port and a DMA/host requester, with WAIT extra cycles per
// access and a hold stall back to the core.
module chad_mem_arbiter #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned AW    = 15,
  parameter int unsigned WAIT  = 0
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic             cpu_rd,
  input  logic             cpu_wr,
  input  logic [AW-1:0]    cpu_addr,
  input  logic [WIDTH-1:0] cpu_wdata,
  output logic [WIDTH-1:0] cpu_rdata,
  output logic             hold,
  input  logic             dma_req,
  input  logic             dma_we,
  input  logic [AW-1:0]    dma_addr,
  input  logic [WIDTH-1:0] dma_wdata,
  output logic             dma_ack,
  output logic [WIDTH-1:0] dma_rdata,
  output logic             ram_en,
  output logic             ram_we,
  output logic [AW-1:0]    ram_addr,
  output logic [WIDTH-1:0] ram_wdata,
  input  logic [WIDTH-1:0] ram_rdata
);

  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  typedef enum logic [1:0] {IDLE, BUSY_CPU, BUSY_DMA} state_e;
  typedef enum logic [1:0] {SRC_NONE, SRC_CPU, SRC_DMA} src_e;

  state_e           state_q, state_d;
  src_e             src_q, src_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             last_dma_q, last_dma_d;
  logic             we_q, we_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] cpu_rdata_q, dma_rdata_q;

  logic cpu_req;
  logic grant_cpu, grant_dma;
  logic own_cpu, own_dma;
  logic fin;

  // Arbitration in IDLE: single requester wins, conflicts go to the party
  // that was not granted last. Gated by resetq so an asserted reset drops
  // the RAM controls immediately even with requests pending.
  always_comb begin
    cpu_req   = cpu_rd | cpu_wr;
    grant_cpu = 1'b0;
    grant_dma = 1'b0;
    if (state_q == IDLE && resetq) begin
      if (cpu_req && dma_req) begin
        grant_cpu = last_dma_q;
        grant_dma = ~last_dma_q;
      end else begin
        grant_cpu = cpu_req;
        grant_dma = dma_req;
      end
    end
    own_cpu = grant_cpu | (state_q == BUSY_CPU);
    own_dma = grant_dma | (state_q == BUSY_DMA);
    fin     = (state_q == IDLE) ? (WAIT_CNT == 4'd0) : (cnt_q == 4'd1);
  end

  // State, counter and captured access registers.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_dma_q  <= 1'b1;
      src_q       <= SRC_NONE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_dma_q  <= last_dma_d;
      src_q       <= src_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  // Next-state: enter BUSY on a grant when WAIT > 0, count down to 1.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_dma_d = last_dma_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    src_d      = SRC_NONE;
    if (fin && own_cpu) src_d = SRC_CPU;
    else if (fin && own_dma) src_d = SRC_DMA;
    case (state_q)
      IDLE: begin
        if (grant_cpu) begin
          last_dma_d = 1'b0;
          we_d       = cpu_wr;
          addr_d     = cpu_addr;
          wdata_d    = cpu_wdata;
          if (WAIT_CNT != 4'd0) begin
            state_d = BUSY_CPU;
            cnt_d   = WAIT_CNT;
          end
        end else if (grant_dma) begin
          last_dma_d = 1'b1;
          we_d       = dma_we;
          addr_d     = dma_addr;
          wdata_d    = dma_wdata;
          if (WAIT_CNT != 4'd0) begin
            state_d = BUSY_DMA;
            cnt_d   = WAIT_CNT;
          end
        end
      end
      BUSY_CPU, BUSY_DMA: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: winner drives the RAM in the grant cycle, captured copy in BUSY.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (state_q != IDLE) begin
      ram_en    = 1'b1;
      ram_we    = we_q;
      ram_addr  = addr_q;
      ram_wdata = wdata_q;
    end else if (grant_cpu) begin
      ram_en    = 1'b1;
      ram_we    = cpu_wr;
      ram_addr  = cpu_addr;
      ram_wdata = cpu_wdata;
    end else if (grant_dma) begin
      ram_en    = 1'b1;
      ram_we    = dma_we;
      ram_addr  = dma_addr;
      ram_wdata = dma_wdata;
    end
    hold      = cpu_req & ~(own_cpu & fin);
    dma_ack   = own_dma & fin;
    cpu_rdata = (src_q == SRC_CPU) ? ram_rdata : cpu_rdata_q;
    dma_rdata = (src_q == SRC_DMA) ? ram_rdata : dma_rdata_q;
  end

  // Per-party read data copies, refreshed only while that party's data is live.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      if (src_q == SRC_CPU) cpu_rdata_q <= ram_rdata;
      if (src_q == SRC_DMA) dma_rdata_q <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_chad_mem_arbiter.sv
// Directed bench for chad_mem_arbiter: four instances with WAIT = 0..3,
// each backed by its own synchronous-read RAM model.
module tb_chad_mem_arbiter;
  localparam int W = 18;
  localparam int A = 15;

  logic clk = 1'b0;
  logic resetq = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]   cpu_rd, cpu_wr, dma_req, dma_we;
  logic [3:0]   hold, dma_ack, ram_en, ram_we;
  logic [A-1:0] cpu_addr [4];
  logic [A-1:0] dma_addr [4];
  logic [A-1:0] ram_addr [4];
  logic [W-1:0] cpu_wdata [4];
  logic [W-1:0] dma_wdata [4];
  logic [W-1:0] cpu_rdata [4];
  logic [W-1:0] dma_rdata [4];
  logic [W-1:0] ram_wdata [4];
  logic [W-1:0] ram_rdata [4];

  logic [W-1:0] mem [4][32768];
  logic         ld_en = 1'b0;
  int           ld_k = 0;
  logic [A-1:0] ld_addr = '0;
  logic [W-1:0] ld_data = '0;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] cpu_q [$];
  logic [W-1:0] dma_q [$];

  genvar g;
  for (g = 0; g < 4; g++) begin : g_dut
    chad_mem_arbiter #(.WIDTH(W), .AW(A), .WAIT(g)) u_dut (
      .clk(clk), .resetq(resetq),
      .cpu_rd(cpu_rd[g]), .cpu_wr(cpu_wr[g]), .cpu_addr(cpu_addr[g]),
      .cpu_wdata(cpu_wdata[g]), .cpu_rdata(cpu_rdata[g]), .hold(hold[g]),
      .dma_req(dma_req[g]), .dma_we(dma_we[g]), .dma_addr(dma_addr[g]),
      .dma_wdata(dma_wdata[g]), .dma_ack(dma_ack[g]), .dma_rdata(dma_rdata[g]),
      .ram_en(ram_en[g]), .ram_we(ram_we[g]), .ram_addr(ram_addr[g]),
      .ram_wdata(ram_wdata[g]), .ram_rdata(ram_rdata[g])
    );
  end

  // RAM models (read-before-write) plus a bench-side preload port.
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (ram_en[k]) begin
        if (ram_we[k]) mem[k][ram_addr[k]] <= ram_wdata[k];
        ram_rdata[k] <= mem[k][ram_addr[k]];
      end
    end
    if (ld_en) mem[ld_k][ld_addr] <= ld_data;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int k, input logic [A-1:0] a, input logic [W-1:0] d);
    ld_en = 1'b1; ld_k = k; ld_addr = a; ld_data = d;
    nxt();
    ld_en = 1'b0;
  endtask

  logic [W-1:0] exp_c, exp_d;
  int ph, cpu_done, acks;

  initial begin
    cpu_rd = '0; cpu_wr = '0; dma_req = '0; dma_we = '0;
    for (int k = 0; k < 4; k++) begin
      cpu_addr[k] = '0; dma_addr[k] = '0; cpu_wdata[k] = '0; dma_wdata[k] = '0;
    end
    nxt();
    load(2, 15'd7, 18'h2A);
    load(0, 15'h20, 18'h111);
    load(0, 15'h30, 18'h222);
    load(1, 15'h40, 18'hAAA);
    load(1, 15'h50, 18'hBBB);
    load(3, 15'h60, 18'h333);

    // reset state on every instance
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rst_en%0d", k), ram_en[k], 0);
      chk($sformatf("rst_we%0d", k), ram_we[k], 0);
      chk($sformatf("rst_addr%0d", k), ram_addr[k], 0);
      chk($sformatf("rst_wdata%0d", k), ram_wdata[k], 0);
      chk($sformatf("rst_ack%0d", k), dma_ack[k], 0);
      chk($sformatf("rst_hold%0d", k), hold[k], 0);
      chk($sformatf("rst_crd%0d", k), cpu_rdata[k], 0);
      chk($sformatf("rst_drd%0d", k), dma_rdata[k], 0);
    end
    nxt(); resetq = 1'b1;

    // WAIT=0: CPU write then read, zero overhead
    nxt(); cpu_wr[0] = 1'b1; cpu_addr[0] = 15'd3; cpu_wdata[0] = 18'h155;
    @(negedge clk);
    chk("t1_wr_hold", hold[0], 0);
    chk("t1_wr_en", ram_en[0], 1);
    chk("t1_wr_we", ram_we[0], 1);
    chk("t1_wr_addr", ram_addr[0], 3);
    chk("t1_wr_data", ram_wdata[0], 18'h155);
    nxt(); cpu_wr[0] = 1'b0; cpu_rd[0] = 1'b1; cpu_q.push_back(18'h155);
    @(negedge clk);
    chk("t1_rd_hold", hold[0], 0);
    chk("t1_rd_we", ram_we[0], 0);
    nxt(); cpu_rd[0] = 1'b0;
    @(negedge clk);
    chk("t1_rdata", cpu_rdata[0], cpu_q.pop_front());

    // WAIT=2: CPU read, 3 cycles of ram_en, hold 1,1,0
    nxt(); cpu_rd[2] = 1'b1; cpu_addr[2] = 15'd7; cpu_q.push_back(18'h2A);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("t2_en%0d", i), ram_en[2], 1);
      chk($sformatf("t2_addr%0d", i), ram_addr[2], 7);
      chk($sformatf("t2_hold%0d", i), hold[2], (i < 2) ? 1 : 0);
      if (i < 2) nxt();
    end
    nxt(); cpu_rd[2] = 1'b0;
    @(negedge clk);
    chk("t2_rdata", cpu_rdata[2], cpu_q.pop_front());
    chk("t2_en_off", ram_en[2], 0);

    nxt(); resetq = 1'b0;
    nxt(); resetq = 1'b1;

    // WAIT=0: simultaneous CPU and DMA reads from reset, CPU first
    nxt();
    cpu_rd[0] = 1'b1; cpu_addr[0] = 15'h20;
    dma_req[0] = 1'b1; dma_we[0] = 1'b0; dma_addr[0] = 15'h30;
    cpu_q.push_back(18'h111); dma_q.push_back(18'h222);
    @(negedge clk);
    chk("t3_hold", hold[0], 0);
    chk("t3_ack0", dma_ack[0], 0);
    chk("t3_addr0", ram_addr[0], 15'h20);
    exp_c = cpu_q.pop_front(); exp_d = dma_q.pop_front();
    nxt(); cpu_rd[0] = 1'b0;
    @(negedge clk);
    chk("t3_ack1", dma_ack[0], 1);
    chk("t3_addr1", ram_addr[0], 15'h30);
    chk("t3_crd1", cpu_rdata[0], exp_c);
    nxt(); dma_req[0] = 1'b0;
    @(negedge clk);
    chk("t3_ack2", dma_ack[0], 0);
    chk("t3_drd2", dma_rdata[0], exp_d);
    chk("t3_crd2", cpu_rdata[0], exp_c);
    nxt();
    @(negedge clk);
    chk("t3_drd3", dma_rdata[0], exp_d);
    chk("t3_crd3", cpu_rdata[0], exp_c);

    // WAIT=1: continuous DMA and CPU requests alternate C,C,D,D
    nxt();
    cpu_rd[1] = 1'b1; cpu_addr[1] = 15'h40;
    dma_req[1] = 1'b1; dma_we[1] = 1'b0; dma_addr[1] = 15'h50;
    cpu_done = 0; acks = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      ph = c % 4;
      chk($sformatf("t4_hold%0d", c), hold[1], (ph != 1) ? 1 : 0);
      chk($sformatf("t4_ack%0d", c), dma_ack[1], (ph == 3) ? 1 : 0);
      chk($sformatf("t4_addr%0d", c), ram_addr[1], (ph < 2) ? 15'h40 : 15'h50);
      if (ph == 2) chk($sformatf("t4_crd%0d", c), cpu_rdata[1], 18'hAAA);
      if (ph == 0 && c >= 4) chk($sformatf("t4_drd%0d", c), dma_rdata[1], 18'hBBB);
      cpu_done += (hold[1] == 1'b0) ? 1 : 0;
      acks += (dma_ack[1] == 1'b1) ? 1 : 0;
      nxt();
    end
    cpu_rd[1] = 1'b0; dma_req[1] = 1'b0;
    chk("t4_cpu_count", cpu_done, 3);
    chk("t4_dma_count", acks, 3);

    // WAIT=3: reset during second BUSY_DMA cycle, then re-request
    nxt(); dma_req[3] = 1'b1; dma_we[3] = 1'b0; dma_addr[3] = 15'h60;
    dma_q.push_back(18'h333);
    @(negedge clk);
    chk("t5_en0", ram_en[3], 1);
    chk("t5_addr0", ram_addr[3], 15'h60);
    chk("t5_ack0", dma_ack[3], 0);
    nxt();
    @(negedge clk);
    chk("t5_ack1", dma_ack[3], 0);
    nxt();
    #2; resetq = 1'b0; #1;
    chk("t5_rst_en", ram_en[3], 0);
    chk("t5_rst_we", ram_we[3], 0);
    chk("t5_rst_addr", ram_addr[3], 0);
    chk("t5_rst_wdata", ram_wdata[3], 0);
    chk("t5_rst_hold", hold[3], 0);
    chk("t5_rst_ack", dma_ack[3], 0);
    nxt(); resetq = 1'b1;
    @(negedge clk);
    chk("t5_re_en", ram_en[3], 1);
    chk("t5_re_addr", ram_addr[3], 15'h60);
    chk("t5_re_ack0", dma_ack[3], 0);
    for (int i = 0; i < 3; i++) begin
      nxt();
      @(negedge clk);
      chk($sformatf("t5_re_ack%0d", i + 1), dma_ack[3], (i == 2) ? 1 : 0);
    end
    nxt(); dma_req[3] = 1'b0;
    @(negedge clk);
    chk("t5_drd", dma_rdata[3], dma_q.pop_front());
    chk("t5_en_off", ram_en[3], 0);

    // WAIT=0: full-range DMA write then CPU read of top address
    nxt();
    dma_req[0] = 1'b1; dma_we[0] = 1'b1; dma_addr[0] = 15'h7FFF; dma_wdata[0] = 18'h3FFFF;
    @(negedge clk);
    chk("t6_ack", dma_ack[0], 1);
    chk("t6_waddr", ram_addr[0], 15'h7FFF);
    chk("t6_we", ram_we[0], 1);
    chk("t6_wdata", ram_wdata[0], 18'h3FFFF);
    nxt();
    dma_req[0] = 1'b0; dma_we[0] = 1'b0;
    cpu_rd[0] = 1'b1; cpu_addr[0] = 15'h7FFF; cpu_q.push_back(18'h3FFFF);
    @(negedge clk);
    chk("t6_hold", hold[0], 0);
    chk("t6_raddr", ram_addr[0], 15'h7FFF);
    chk("t6_rwe", ram_we[0], 0);
    nxt(); cpu_rd[0] = 1'b0;
    @(negedge clk);
    chk("t6_rdata", cpu_rdata[0], cpu_q.pop_front());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
